// File: rtl/exe_stage_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS execute stage: opcodes, branch
// types, forwarding selects and the FSM state.
package exe_pkg;

    typedef enum logic [3:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd2,
        CMD_AND = 4'd4,
        CMD_OR  = 4'd5,
        CMD_NOR = 4'd6,
        CMD_XOR = 4'd7,
        CMD_SLL = 4'd8,
        CMD_SRA = 4'd9,
        CMD_SRL = 4'd10,
        CMD_MUL = 4'd12
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    typedef enum logic [1:0] {
        FWD_OWN  = 2'd0,
        FWD_EXE  = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_OWN2 = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/exe_stage_mc_if.sv
// ID/EX -> EX/MEM bundle of the execute stage; master is the pipeline side,
// slave is the execute stage itself.
interface exe_stage_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [3:0]      exe_cmd;
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;
    logic [XLEN-1:0] val_src2;
    logic [XLEN-1:0] pc;
    logic [1:0]      br_type;
    logic [XLEN-1:0] exe_st_val;
    logic [XLEN-1:0] mem_st_val;
    logic [1:0]      val1_fwd;
    logic [1:0]      val2_fwd;
    logic [1:0]      src2_fwd;
    logic            flush;
    logic            stall;
    logic            out_valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] st_val;
    logic            br_taken;
    logic [XLEN-1:0] br_addr;

    modport master (
        output in_valid, exe_cmd, val1, val2, val_src2, pc, br_type,
               exe_st_val, mem_st_val, val1_fwd, val2_fwd, src2_fwd, flush,
        input  stall, out_valid, alu_result, st_val, br_taken, br_addr
    );

    modport slave (
        input  in_valid, exe_cmd, val1, val2, val_src2, pc, br_type,
               exe_st_val, mem_st_val, val1_fwd, val2_fwd, src2_fwd, flush,
        output stall, out_valid, alu_result, st_val, br_taken, br_addr
    );
endinterface

// File: rtl/exe_stage_mc_iter_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// XLEN cycles per operation, low XLEN bits of the product kept.
module iter_mul #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);
    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_acc;
    logic [CW-1:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_kill) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= CW'(XLEN);
        end else if (r_cnt != '0) begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // done flags the cycle whose edge retires the final partial product
    assign o_busy    = (r_cnt != '0);
    assign o_done    = (r_cnt == CW'(1));
    assign o_product = r_acc;

endmodule

// File: rtl/exe_stage_mc.sv
// MIPS execute stage: forwarding muxes, inline ALU and branch check, registered
// EX/MEM outputs, and an iterative multiplier that stalls the front end.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    exe_stage_mc_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    state_e          r_state, w_state_nxt;
    logic            r_valid, r_taken;
    logic [XLEN-1:0] r_result, r_st, r_addr;
    logic [XLEN-1:0] w_f1, w_f2, w_fs, w_a, w_alu, w_tgt, w_product;
    logic [SHW-1:0]  w_sh;
    logic            w_taken, w_stall, w_mul_start, w_mul_busy, w_mul_done;

    function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel, input logic [XLEN-1:0] own,
                                            input logic [XLEN-1:0] exe, input logic [XLEN-1:0] mem);
        case (sel)
            FWD_EXE: return exe;
            FWD_MEM: return mem;
            default: return own;
        endcase
    endfunction

    assign w_f1  = fwd(bus.val1_fwd, bus.val1, bus.exe_st_val, bus.mem_st_val);
    assign w_f2  = fwd(bus.val2_fwd, bus.val2, bus.exe_st_val, bus.mem_st_val);
    assign w_fs  = fwd(bus.src2_fwd, bus.val_src2, bus.exe_st_val, bus.mem_st_val);
    assign w_a   = (bus.br_type != BR_NONE) ? bus.pc : w_f1;
    assign w_sh  = w_f2[SHW-1:0];
    assign w_tgt = bus.pc + w_f2;

    // MUL with MUL_EN=0 falls to the default arm and yields 0 in one cycle
    always_comb begin
        w_alu = '0;
        case (bus.exe_cmd)
            CMD_ADD: w_alu = w_a + w_f2;
            CMD_SUB: w_alu = w_a - w_f2;
            CMD_AND: w_alu = w_a & w_f2;
            CMD_OR:  w_alu = w_a | w_f2;
            CMD_NOR: w_alu = ~(w_a | w_f2);
            CMD_XOR: w_alu = w_a ^ w_f2;
            CMD_SLL: w_alu = w_a << w_sh;
            CMD_SRA: w_alu = $unsigned($signed(w_a) >>> w_sh);
            CMD_SRL: w_alu = w_a >> w_sh;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (bus.br_type)
            BR_BEZ:  w_taken = (w_f1 == '0);
            BR_BNE:  w_taken = (w_f1 != w_fs);
            BR_JMP:  w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_mul_start = MUL_EN && !rst && !bus.flush && (r_state == S_IDLE) &&
                         bus.in_valid && (bus.exe_cmd == CMD_MUL);

    iter_mul #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_kill    (bus.flush),
        .i_a       (w_f1),
        .i_b       (w_f2),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: if (w_mul_start) begin
                w_state_nxt = S_MUL;
                w_stall     = 1'b1;
            end
            S_MUL: begin
                w_stall = w_mul_busy;
                if (w_mul_done) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_taken  <= 1'b0;
            r_result <= '0;
            r_st     <= '0;
            r_addr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.flush) begin
                r_valid <= 1'b0;
                r_taken <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (bus.in_valid && !w_mul_start) begin
                        r_valid  <= 1'b1;
                        r_result <= w_alu;
                        r_st     <= w_fs;
                        r_taken  <= w_taken;
                        r_addr   <= w_tgt;
                    end else begin
                        r_valid <= 1'b0;
                        r_taken <= 1'b0;
                    end
                    S_DONE: begin
                        r_valid  <= 1'b1;
                        r_result <= w_product;
                        r_taken  <= 1'b0;
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_taken <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.stall      = w_stall;
    assign bus.out_valid  = r_valid;
    assign bus.alu_result = r_result;
    assign bus.st_val     = r_st;
    assign bus.br_taken   = r_taken;
    assign bus.br_addr    = r_addr;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Scoreboard bench for exe_stage_mc (XLEN=32): expected results are queued at
// issue time and popped by a monitor whenever out_valid is seen.
module tb_exe_stage_mc;
    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] res;
        logic [31:0] st;
        logic        bt;
        logic [31:0] ba;
        logic        chk_st;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    exe_stage_mc_if #(.XLEN(XLEN)) bus ();

    exe_stage_mc #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] own,
                                         input logic [31:0] ex, input logic [31:0] mem);
        if (s == 2'd1) return ex;
        if (s == 2'd2) return mem;
        return own;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b);
        int                 sh;
        logic signed [63:0] sa;
        logic [63:0]        p;
        sh = int'(b % 32);
        sa = a[31] ? $signed({32'b0, a}) - 64'sh1_0000_0000 : $signed({32'b0, a});
        sa = sa >>> sh;
        p  = {32'b0, a} * {32'b0, b};
        case (cmd)
            4'd0:    return a + b;
            4'd2:    return a - b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return ~(a | b);
            4'd7:    return a ^ b;
            4'd8:    return a << sh;
            4'd9:    return sa[31:0];
            4'd10:   return a >> sh;
            4'd12:   return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [1:0] bt, input logic [31:0] f1,
                                       input logic [31:0] fs);
        case (bt)
            2'd1:    return f1 == 32'd0;
            2'd2:    return f1 != fs;
            2'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] vs, input logic [31:0] pc, input logic [31:0] ex,
                         input logic [31:0] mem, input logic [1:0] bt, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [1:0] ss, input logic fl);
        exp_t        e;
        logic [31:0] f1, f2, fs;
        bus.in_valid = 1'b1;  bus.exe_cmd = cmd;   bus.val1 = v1;       bus.val2 = v2;
        bus.val_src2 = vs;    bus.pc = pc;         bus.exe_st_val = ex; bus.mem_st_val = mem;
        bus.br_type = bt;     bus.val1_fwd = s1;   bus.val2_fwd = s2;   bus.src2_fwd = ss;
        bus.flush = fl;
        f1 = pick(s1, v1, ex, mem);
        f2 = pick(s2, v2, ex, mem);
        fs = pick(ss, vs, ex, mem);
        e.res    = ref_alu(cmd, (bt != 2'd0) ? pc : f1, f2);
        e.st     = fs;
        e.bt     = ref_taken(bt, f1, fs);
        e.ba     = pc + f2;
        e.chk_st = 1'b1;
        if (!fl) q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1; bus.exe_cmd = 4'd12; bus.val1 = a;     bus.val2 = b;
        bus.val1_fwd = 2'd0; bus.val2_fwd = 2'd0; bus.src2_fwd = 2'd0;
        bus.br_type  = 2'd0; bus.flush = 1'b0;
    endtask

    // entered at posedge+1 with the stage idle
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        int          cyc, stl;
        logic        done, drop;
        p = {32'b0, a} * {32'b0, b};
        e.res = p[31:0]; e.st = 32'd0; e.bt = 1'b0; e.ba = 32'd0; e.chk_st = 1'b0;
        q.push_back(e);
        start_mul(a, b);
        @(negedge clk);
        chk("stall_on_accept", {31'b0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        cyc = 0; stl = 0; done = 1'b0; drop = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (bus.out_valid) done = 1'b1;
            else begin
                if (bus.stall) stl++;
                else drop = 1'b1;
                @(posedge clk); #1;
                cyc++;
                if (drop) bus.in_valid = 1'b0;
            end
        end
        chk("mul_latency", 32'(cyc), 32'(XLEN + 1));
        chk("mul_stall_cycles", 32'(stl), 32'(XLEN));
        idle(1);
    endtask

    initial begin
        logic [3:0]  cmd;
        logic [31:0] hold;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.exe_cmd = 4'd0; bus.val1 = '0; bus.val2 = '0;
        bus.val_src2 = '0;   bus.pc = '0;        bus.br_type = 2'd0;
        bus.exe_st_val = '0; bus.mem_st_val = '0;
        bus.val1_fwd = 2'd0; bus.val2_fwd = 2'd0; bus.src2_fwd = 2'd0; bus.flush = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst && bus.out_valid) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out: got alu_result %h want no output", bus.alu_result);
                    end else begin
                        e = q.pop_front();
                        chk("alu_result", bus.alu_result, e.res);
                        if (e.chk_st) chk("st_val", bus.st_val, e.st);
                        chk("br_taken", {31'b0, bus.br_taken}, {31'b0, e.bt});
                        if (e.bt) chk("br_addr", bus.br_addr, e.ba);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_alu_result", bus.alu_result, 32'd0);
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        issue(4'd2, 32'd5, 32'd3, 32'd0, 32'd0, 32'd7, 32'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fwd_sub", bus.alu_result, 32'd4);
        chk("fwd_sub_valid", {31'b0, bus.out_valid}, 32'd1);

        issue(4'd0, 32'd9, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0);
        issue(4'd0, 32'd9, 32'h10, 32'd8, 32'h100, 32'd0, 32'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bne_taken", {31'b0, bus.br_taken}, 32'd1);
        chk("bne_addr", bus.br_addr, 32'h110);

        issue(4'd9, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("sra_sign", bus.alu_result, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_no_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("idle_hold_result", bus.alu_result, 32'hFFFF_FFFF);

        issue(4'd8, 32'h1234_5679, 32'd33, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("sll_mask", bus.alu_result, 32'h2468_ACF2);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else begin
                cmd = 4'($urandom_range(0, 15));
                if (cmd == 4'd12) cmd = 4'd0;
                issue(cmd, $urandom(), ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom(),
                      ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom(), $urandom(), $urandom(),
                      ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
            end
        end
        idle(1);

        do_mul(32'hFFFF_FFFF, 32'd3);
        do_mul($urandom(), $urandom());
        do_mul($urandom(), 32'($urandom_range(0, 255)));

        // flush on the 10th busy cycle, with the MUL still presented
        start_mul(32'd1234, 32'd5678);
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_stall", {31'b0, bus.stall}, 32'd0);
        chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        idle(40);

        start_mul(32'd77, 32'd99);
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        hold = bus.alu_result;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rstmul_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rstmul_alu_result", bus.alu_result, 32'd0);
        chk("rstmul_st_val", bus.st_val, 32'd0);
        chk("rstmul_br_addr", bus.br_addr, 32'd0);
        chk("rstmul_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        issue(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_add_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("post_rst_add", bus.alu_result, 32'd2);
        if (hold == 32'd0) $display("note: result before reset was already zero");

        idle(3);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
